pokey_bus_host: RTL and testbench

Bus initiator for the POKEY core's CPU-side interface, the 6502-style host end of the `cs`/`rw`/`a`/`d` bus.
- Generates the 1.79 MHz phase clock (`phi2`) from the fast system clock and converts single register requests (valid/ready) into correctly phased bus cycles.
- Captures read data and returns a one-cycle response.
- Sits in the FPGA prototype and test harness wherever no real CPU drives POKEY: its outputs connect to POKEY's `clk179`, `cs`, `rw`, `a` and `d`.

---
 rtl/pokey_bus_pkg.sv | 14 +
 rtl/pokey_phi2_gen.sv | 35 +++
 rtl/pokey_bus_host.sv | 121 ++++++++++++
 tb/tb_pokey_bus_host.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pokey_bus_pkg.sv
// Shared constants and state type for the POKEY host-side bus initiator.
package pokey_bus_pkg;

  localparam logic [1:0] CS_SEL  = 2'b10;
  localparam logic [1:0] CS_IDLE = 2'b01;
  localparam logic       RW_READ = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } bus_state_t;

endpackage

// File: rtl/pokey_phi2_gen.sv
// Free-running phi2 generator: phase counter plus phase register, with
// strobes marking the last fast cycle of each phi2 half period.
module pokey_phi2_gen #(
  parameter int unsigned HALF_PERIOD = 17
) (
  input  logic clk,
  input  logic rst,
  output logic phi2,
  output logic last_low,
  output logic last_high
);

  logic [7:0] r_pc;
  logic       r_phi2;
  logic       w_wrap;

  assign w_wrap = (r_pc == 8'(HALF_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= '0;
      r_phi2 <= 1'b0;
    end else if (w_wrap) begin
      r_pc   <= '0;
      r_phi2 <= ~r_phi2;
    end else begin
      r_pc   <= r_pc + 8'd1;
    end
  end

  assign phi2      = r_phi2;
  assign last_low  = w_wrap & ~r_phi2;
  assign last_high = w_wrap &  r_phi2;

endmodule

// File: rtl/pokey_bus_host.sv
// 6502-style bus initiator for POKEY: turns valid/ready register requests
// into phi2-aligned bus cycles and returns a one-cycle response pulse.
module pokey_bus_host
  import pokey_bus_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       phi2,
  output logic [1:0] cs,
  output logic       rw,
  output logic [3:0] a,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in,
  output logic       busy
);

  bus_state_t r_state, w_next;
  logic       w_last_low, w_last_high, w_ready, w_accept, w_cycle_end;
  logic [1:0] r_cs;
  logic       r_rw, r_d_oe, r_oe_hold, r_rsp_valid;
  logic [3:0] r_a;
  logic [7:0] r_wdata, r_d_out, r_rsp_rdata;

  pokey_phi2_gen #(.HALF_PERIOD(HALF_PERIOD)) u_phi2 (
    .clk       (clk),
    .rst       (rst),
    .phi2      (phi2),
    .last_low  (w_last_low),
    .last_high (w_last_high)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = w_last_high;
        if (w_last_high && req_valid) w_next = LOW;
      end
      LOW: begin
        if (w_last_low) w_next = HIGH;
      end
      HIGH: begin
        w_ready = w_last_high;
        if (w_last_high) w_next = req_valid ? LOW : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept    = w_ready & req_valid;
  assign w_cycle_end = (r_state == HIGH) & w_last_high;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs        <= CS_IDLE;
      r_rw        <= RW_READ;
      r_a         <= '0;
      r_wdata     <= '0;
      r_d_out     <= '0;
      r_d_oe      <= 1'b0;
      r_oe_hold   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (r_oe_hold) begin
        r_d_oe    <= 1'b0;
        r_oe_hold <= 1'b0;
      end
      if (w_accept) begin
        r_cs    <= CS_SEL;
        r_rw    <= req_rw;
        r_a     <= req_addr;
        r_wdata <= req_wdata;
      end else if (w_cycle_end) begin
        r_cs <= CS_IDLE;
        r_rw <= RW_READ;
      end
      if ((r_state == LOW) && w_last_low && (r_rw != RW_READ)) begin
        r_d_oe  <= 1'b1;
        r_d_out <= r_wdata;
      end
      // A finishing write keeps the pad driven one cycle past the falling
      // edge, or indefinitely when another write follows immediately.
      if (w_cycle_end) begin
        r_rsp_valid <= 1'b1;
        if (r_rw == RW_READ)
          r_rsp_rdata <= d_in;
        else if (!(w_accept && (req_rw != RW_READ)))
          r_oe_hold <= 1'b1;
      end
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign cs        = r_cs;
  assign rw        = r_rw;
  assign a         = r_a;
  assign d_out     = r_d_out;
  assign d_oe      = r_d_oe;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_pokey_bus_host.sv
// Randomized bench for pokey_bus_host: a timeline model of accepted bus
// transactions predicts every output on every fast-clock cycle.
module tb_pokey_bus_host;

  localparam int HP = 4;
  localparam int BP = 2 * HP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       phi2;
  logic [1:0] cs;
  logic       rw;
  logic [3:0] a;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in = '0;
  logic       busy;

  pokey_bus_host #(.HALF_PERIOD(HP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .phi2      (phi2),
    .cs        (cs),
    .rw        (rw),
    .a         (a),
    .d_out     (d_out),
    .d_oe      (d_oe),
    .d_in      (d_in),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Transaction starting at edge count 'a' occupies the BP cycles after it.
  typedef struct {
    int       a;
    bit       rd;
    bit [3:0] addr;
    bit [7:0] wdata;
  } txn_t;

  txn_t     txq[$];
  bit [7:0] din_hist[int];
  int       k;
  int       n_tests = 0;
  int       n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic check_all();
    bit       busy_e = 0, rspv_e = 0, doe_e = 0, rw_e = 1;
    bit [1:0] cs_e = 2'b01;
    bit [3:0] a_e = '0;
    bit [7:0] dout_e = '0, rdata_e = '0;
    bit       wr_end[int];
    foreach (txq[i]) if (!txq[i].rd) wr_end[txq[i].a + BP] = 1'b1;
    foreach (txq[i]) begin
      txn_t t = txq[i];
      if (t.a <= k) a_e = t.addr;
      if (!t.rd && t.a + HP <= k) dout_e = t.wdata;
      if (t.rd && t.a + BP <= k) rdata_e = din_hist[t.a + BP - 1];
      if (t.a + BP == k) rspv_e = 1'b1;
      if (!t.rd && t.a + BP == k) doe_e = 1'b1;
      if (t.a <= k && k < t.a + BP) begin
        busy_e = 1'b1;
        cs_e   = 2'b10;
        rw_e   = t.rd;
        if (!t.rd && (k >= t.a + HP || wr_end.exists(t.a))) doe_e = 1'b1;
      end
    end
    check_eq("phi2",      phi2,      32'((k / HP) % 2));
    check_eq("req_ready", req_ready, 32'(k % BP == BP - 1));
    check_eq("busy",      busy,      busy_e);
    check_eq("cs",        cs,        cs_e);
    check_eq("rw",        rw,        rw_e);
    check_eq("a",         a,         a_e);
    check_eq("d_oe",      d_oe,      doe_e);
    check_eq("d_out",     d_out,     dout_e);
    check_eq("rsp_valid", rsp_valid, rspv_e);
    check_eq("rsp_rdata", rsp_rdata, rdata_e);
  endtask

  task automatic step(input int pct);
    bit acc;
    @(posedge clk);
    acc = req_valid && (k % BP == BP - 1);
    if (acc) begin
      txn_t t;
      t.a = k + 1; t.rd = req_rw; t.addr = req_addr; t.wdata = req_wdata;
      txq.push_back(t);
    end
    k++;
    @(negedge clk);
    check_all();
    if (!req_valid || acc) begin
      req_valid = ($urandom_range(99) < pct);
      req_rw    = 1'($urandom_range(1));
      req_addr  = 4'($urandom);
      req_wdata = 8'($urandom);
    end
    d_in = 8'($urandom);
    din_hist[k] = d_in;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    txq.delete();
    din_hist.delete();
    d_in = 8'($urandom);
    din_hist[0] = d_in;
    check_all();
  endtask

  task automatic reset_during_write();
    bit hit = 0;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'h8; req_wdata = 8'h5A;
    for (int c = 0; c < 4 * BP && !hit; c++) begin
      step(0);
      if (txq.size() > 0 && !txq[$].rd && k == txq[$].a + HP + 1) hit = 1;
    end
    check_eq("rst_wait_write_high", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_cs",        cs,        32'h1);
    check_eq("rst_rw",        rw,        32'h1);
    check_eq("rst_d_oe",      d_oe,      32'h0);
    check_eq("rst_busy",      busy,      32'h0);
    check_eq("rst_phi2",      phi2,      32'h0);
    check_eq("rst_a",         a,         32'h0);
    check_eq("rst_d_out",     d_out,     32'h0);
    check_eq("rst_req_ready", req_ready, 32'h0);
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rst_rsp_valid", rsp_valid, 32'h0);
    end
    release_reset();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    release_reset();
    for (int c = 0; c < 200; c++) step(30);
    for (int c = 0; c < 200; c++) step(95);
    reset_during_write();
    for (int c = 0; c < 150; c++) step(60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
